// File: rtl/frame_draw_scheduler.sv
// Frame draw scheduler: clears the back buffer, then scans sprite rectangles round-robin into the draw port.
// Optional dropped-frame counter enabled by defining FRAME_OVERRUN_CNT_EN.
module frame_draw_scheduler #(
  parameter int N      = 4,
  parameter int WIN_X0 = 115,
  parameter int WIN_Y0 = 80,
  parameter int WIN_W  = 410,
  parameter int WIN_H  = 320
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            frame_clk_rising_edge,
  input  logic [N-1:0]    req,
  input  logic [N*10-1:0] rect_x,
  input  logic [N*10-1:0] rect_y,
  input  logic [N*10-1:0] rect_w,
  input  logic [N*10-1:0] rect_h,
  input  logic [N*24-1:0] pix_data,
  output logic [N-1:0]    grant,
  output logic [N-1:0]    done,
  output logic [9:0]      off_x,
  output logic [9:0]      off_y,
  output logic [9:0]      DrawX,
  output logic [9:0]      DrawY,
  output logic [23:0]     draw_data,
  output logic            clear_start,
  output logic            frame_done
`ifdef FRAME_OVERRUN_CNT_EN
  ,
  output logic [15:0]     overrun_cnt,
  input  logic            overrun_clr
`endif
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [9:0] X0 = 10'(WIN_X0);
  localparam logic [9:0] Y0 = 10'(WIN_Y0);
  localparam logic [9:0] LAST_CX = 10'(WIN_W - 1);
  localparam logic [9:0] LAST_CY = 10'(WIN_H - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic [1:0] {CLEAR, ARB, SCAN, DONE} state_t;

  state_t        state_q, state_d;
  logic [9:0]    cntX_q, cntX_d, cntY_q, cntY_d;
  logic [N-1:0]  served_q, served_d, grant_q, grant_d, done_q, done_d;
  logic [IW-1:0] rr_q, rr_d, idx_q, idx_d;
  logic [9:0]    drawX_q, drawX_d, drawY_q, drawY_d;
  logic [23:0]   data_q, data_d;
  logic          clearStart_q, clearStart_d, frameDone_q;

  logic [N-1:0]  eligible;
  logic          found;
  logic [IW-1:0] sel;
  logic [9:0]    rx, ry, rw, rh, px, py;
  logic [23:0]   pixSel;
  logic          emptyRect, inWin, lastPix;

  assign rx     = rect_x[int'(idx_q)*10 +: 10];
  assign ry     = rect_y[int'(idx_q)*10 +: 10];
  assign rw     = rect_w[int'(idx_q)*10 +: 10];
  assign rh     = rect_h[int'(idx_q)*10 +: 10];
  assign pixSel = pix_data[int'(idx_q)*24 +: 24];
  assign px     = rx + cntX_q;
  assign py     = ry + cntY_q;
  assign emptyRect = (rw == 10'd0) || (rh == 10'd0);
  assign inWin  = (int'(px) >= WIN_X0) && (int'(px) < WIN_X0 + WIN_W) &&
                  (int'(py) >= WIN_Y0) && (int'(py) < WIN_Y0 + WIN_H);
  assign lastPix = emptyRect || ((cntX_q == rw - 10'd1) && (cntY_q == rh - 10'd1));
  assign eligible = req & ~served_q;

  // First eligible requester at or after the round-robin pointer, wrapping.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && eligible[(int'(rr_q) + k) % N]) begin
        found = 1'b1;
        sel   = IW'((int'(rr_q) + k) % N);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cntX_d       = cntX_q;
    cntY_d       = cntY_q;
    served_d     = served_q;
    rr_d         = rr_q;
    idx_d        = idx_q;
    grant_d      = grant_q;
    done_d       = '0;
    drawX_d      = drawX_q;
    drawY_d      = drawY_q;
    data_d       = '0;
    clearStart_d = 1'b0;
    case (state_q)
      CLEAR: begin
        drawX_d      = X0 + cntX_q;
        drawY_d      = Y0 + cntY_q;
        clearStart_d = 1'b1;
        if (cntX_q == LAST_CX) begin
          cntX_d = '0;
          if (cntY_q == LAST_CY) begin
            cntY_d  = '0;
            state_d = ARB;
          end else begin
            cntY_d = cntY_q + 10'd1;
          end
        end else begin
          cntX_d = cntX_q + 10'd1;
        end
      end
      ARB: begin
        if (found) begin
          grant_d      = '0;
          grant_d[sel] = 1'b1;
          idx_d        = sel;
          cntX_d       = '0;
          cntY_d       = '0;
          state_d      = SCAN;
        end else begin
          state_d = DONE;
        end
      end
      SCAN: begin
        drawX_d = px;
        drawY_d = py;
        // Off-window pixels still take a cycle; zero data suppresses the write.
        if (!emptyRect && inWin) data_d = pixSel;
        if (lastPix) begin
          done_d[idx_q]   = 1'b1;
          served_d[idx_q] = 1'b1;
          rr_d    = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
          grant_d = '0;
          cntX_d  = '0;
          cntY_d  = '0;
          state_d = ARB;
        end else if (cntX_q == rw - 10'd1) begin
          cntX_d = '0;
          cntY_d = cntY_q + 10'd1;
        end else begin
          cntX_d = cntX_q + 10'd1;
        end
      end
      DONE: begin
        if (frame_clk_rising_edge) begin
          served_d = '0;
          cntX_d   = '0;
          cntY_d   = '0;
          state_d  = CLEAR;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= CLEAR;
      cntX_q       <= '0;
      cntY_q       <= '0;
      served_q     <= '0;
      rr_q         <= '0;
      idx_q        <= '0;
      grant_q      <= '0;
      done_q       <= '0;
      drawX_q      <= '0;
      drawY_q      <= '0;
      data_q       <= '0;
      clearStart_q <= 1'b0;
      frameDone_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cntX_q       <= cntX_d;
      cntY_q       <= cntY_d;
      served_q     <= served_d;
      rr_q         <= rr_d;
      idx_q        <= idx_d;
      grant_q      <= grant_d;
      done_q       <= done_d;
      drawX_q      <= drawX_d;
      drawY_q      <= drawY_d;
      data_q       <= data_d;
      clearStart_q <= clearStart_d;
      frameDone_q  <= (state_d == DONE);
    end
  end

`ifdef FRAME_OVERRUN_CNT_EN
  logic [15:0] overrun_q;

  // A frame edge arriving before the schedule reached DONE is a dropped frame.
  always_ff @(posedge Clk) begin
    if (Reset || overrun_clr) begin
      overrun_q <= '0;
    end else if (frame_clk_rising_edge && (state_q != DONE) && (overrun_q != 16'hFFFF)) begin
      overrun_q <= overrun_q + 16'd1;
    end
  end

  assign overrun_cnt = overrun_q;
`endif

  assign grant       = grant_q;
  assign done        = done_q;
  assign off_x       = cntX_q;
  assign off_y       = cntY_q;
  assign DrawX       = drawX_q;
  assign DrawY       = drawY_q;
  assign draw_data   = data_q;
  assign clear_start = clearStart_q;
  assign frame_done  = frameDone_q;

endmodule

// File: tb/tb_frame_draw_scheduler.sv
// Testbench for frame_draw_scheduler: a per-cycle expected trace is built from the scheduling rules and compared each cycle.
// A reduced window keeps each clear pass short.
module tb_frame_draw_scheduler;

  localparam int TN  = 4;
  localparam int TX0 = 115;
  localparam int TY0 = 80;
  localparam int TW  = 20;
  localparam int TH  = 10;

  localparam int K_CLEAR = 0;
  localparam int K_ARB   = 1;
  localparam int K_SCAN  = 2;
  localparam int K_DONE  = 3;

  typedef struct {
    int          kind;
    int          x;
    int          y;
    logic [23:0] data;
    int          idx;
    bit          last;
  } ent_t;

  logic              Clk;
  logic              Reset;
  logic              frameEdge;
  logic [TN-1:0]     reqV;
  logic [TN*10-1:0]  rectX, rectY, rectW, rectH;
  logic [TN*24-1:0]  pixData;
  logic [TN-1:0]     grant, done;
  logic [9:0]        offX, offY, DrawX, DrawY;
  logic [23:0]       drawData;
  logic              clearStart, frameDone;
`ifdef FRAME_OVERRUN_CNT_EN
  logic [15:0]       overrunCnt;
  logic              overrunClr;
`endif

  int          rxA [TN];
  int          ryA [TN];
  int          rwA [TN];
  int          rhA [TN];
  logic [23:0] baseCol [TN];
  bit          patOn;

  ent_t  q[$];
  int    cmpCount = 0;
  int    errCount = 0;
  int    rrM = 0;
  int    ovrM = 0;
  string curTag;

  frame_draw_scheduler #(
    .N(TN), .WIN_X0(TX0), .WIN_Y0(TY0), .WIN_W(TW), .WIN_H(TH)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .frame_clk_rising_edge(frameEdge),
    .req(reqV),
    .rect_x(rectX),
    .rect_y(rectY),
    .rect_w(rectW),
    .rect_h(rectH),
    .pix_data(pixData),
    .grant(grant),
    .done(done),
    .off_x(offX),
    .off_y(offY),
    .DrawX(DrawX),
    .DrawY(DrawY),
    .draw_data(drawData),
    .clear_start(clearStart),
    .frame_done(frameDone)
`ifdef FRAME_OVERRUN_CNT_EN
    ,
    .overrun_cnt(overrunCnt),
    .overrun_clr(overrunClr)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [23:0] pixOf(input logic [23:0] base, input bit pat, input int ox, input int oy);
    logic [9:0] x10 = 10'(ox);
    logic [9:0] y10 = 10'(oy);
    return pat ? (base ^ {4'h0, y10, x10}) : base;
  endfunction

  function automatic bit inWin(input int x, input int y);
    return (x >= TX0) && (x < TX0 + TW) && (y >= TY0) && (y < TY0 + TH);
  endfunction

  // Sprite source: colour is a function of the offset the scheduler presents.
  always_comb begin
    for (int i = 0; i < TN; i++) begin
      rectX[i*10 +: 10]  = 10'(rxA[i]);
      rectY[i*10 +: 10]  = 10'(ryA[i]);
      rectW[i*10 +: 10]  = 10'(rwA[i]);
      rectH[i*10 +: 10]  = 10'(rhA[i]);
      pixData[i*24 +: 24] = pixOf(baseCol[i], patOn, int'(offX), int'(offY));
    end
  end

  task automatic buildFrame(input int nDone);
    logic [TN-1:0] served;
    int found;
    served = '0;
    q.delete();
    for (int cy = 0; cy < TH; cy++)
      for (int cx = 0; cx < TW; cx++)
        q.push_back('{kind: K_CLEAR, x: TX0 + cx, y: TY0 + cy, data: 24'h0, idx: 0, last: 1'b0});
    forever begin
      found = -1;
      for (int k = 0; k < TN; k++) begin
        int j = (rrM + k) % TN;
        if (found < 0 && reqV[j] && !served[j]) found = j;
      end
      q.push_back('{kind: K_ARB, x: 0, y: 0, data: 24'h0, idx: 0, last: 1'b0});
      if (found < 0) break;
      if (rwA[found] == 0 || rhA[found] == 0) begin
        q.push_back('{kind: K_SCAN, x: rxA[found], y: ryA[found], data: 24'h0, idx: found, last: 1'b1});
      end else begin
        for (int oy = 0; oy < rhA[found]; oy++) begin
          for (int ox = 0; ox < rwA[found]; ox++) begin
            int x = (rxA[found] + ox) % 1024;
            int y = (ryA[found] + oy) % 1024;
            logic [23:0] d = inWin(x, y) ? pixOf(baseCol[found], patOn, ox, oy) : 24'h0;
            q.push_back('{kind: K_SCAN, x: x, y: y, data: d, idx: found,
                          last: (ox == rwA[found] - 1) && (oy == rhA[found] - 1)});
          end
        end
      end
      served[found] = 1'b1;
      rrM = (found + 1) % TN;
    end
    for (int d = 0; d < nDone; d++)
      q.push_back('{kind: K_DONE, x: 0, y: 0, data: 24'h0, idx: 0, last: 1'b0});
  endtask

  task automatic checkOutput(input ent_t e, input ent_t nx, input int c);
    logic [53:0] obs, expv;
    logic [TN-1:0] g, d;
    g = (nx.kind == K_SCAN) ? TN'(1 << nx.idx) : '0;
    d = (e.kind == K_SCAN && e.last) ? TN'(1 << e.idx) : '0;
    expv = {10'(e.x), 10'(e.y), e.data, (e.kind == K_CLEAR), g, d, (nx.kind == K_DONE)};
    obs  = {DrawX, DrawY, drawData, clearStart, grant, done, frameDone};
    cmpCount++;
    if (e.kind == K_CLEAR || e.kind == K_SCAN) begin
      assert (obs === expv) else begin
        errCount++;
        $error("[TB] FAIL %s cyc %0d: observed %h required %h", curTag, c, obs, expv);
      end
    end else begin
      assert (obs[33:0] === expv[33:0]) else begin
        errCount++;
        $error("[TB] FAIL %s cyc %0d: observed %h required %h", curTag, c, obs[33:0], expv[33:0]);
      end
    end
  endtask

  // Drives the frame's cycles; sA/sB/sC are stray frame edges inside the clear pass.
  task automatic runFrame(input int stopAt, input int sA, input int sB, input int sC, input bit clrC);
    int n, lim;
    ent_t nx;
    n   = q.size();
    lim = (stopAt < 0) ? n : stopAt;
    for (int c = 0; c < lim; c++) begin
      frameEdge = (c == n - 1) || (c == sA) || (c == sB) || (c == sC);
`ifdef FRAME_OVERRUN_CNT_EN
      overrunClr = clrC && (c == sC);
      if (clrC && c == sC) ovrM = 0;
      else if (c != n - 1 && (c == sA || c == sB || c == sC)) ovrM = (ovrM < 65535) ? ovrM + 1 : ovrM;
`endif
      @(posedge Clk);
      #1;
      frameEdge = 1'b0;
`ifdef FRAME_OVERRUN_CNT_EN
      overrunClr = 1'b0;
`endif
      if (c + 1 < n) nx = q[c + 1];
      else nx = '{kind: K_CLEAR, x: 0, y: 0, data: 24'h0, idx: 0, last: 1'b0};
      checkOutput(q[c], nx, c);
    end
`ifdef FRAME_OVERRUN_CNT_EN
    if (stopAt < 0) begin
      cmpCount++;
      assert (overrunCnt === 16'(ovrM)) else begin
        errCount++;
        $error("[TB] FAIL %s overrun_cnt: observed %0d required %0d", curTag, overrunCnt, ovrM);
      end
    end
`else
    if (clrC) $display("[TB] %s: clear request ignored in this build", curTag);
`endif
  endtask

  task automatic applyStimulus(input logic [TN-1:0] r, input bit randomRects);
    reqV = r;
    if (randomRects) begin
      patOn = 1'b1;
      for (int i = 0; i < TN; i++) begin
        rxA[i] = ($urandom_range(0, 9) == 0) ? 1020 + int'($urandom_range(0, 3)) : 105 + int'($urandom_range(0, 35));
        ryA[i] = 75 + int'($urandom_range(0, 18));
        rwA[i] = int'($urandom_range(0, 5));
        rhA[i] = int'($urandom_range(0, 3));
        baseCol[i] = 24'($urandom);
      end
    end
  endtask

  task automatic checkResetState(input string tag);
    cmpCount++;
    assert ({DrawX, DrawY, drawData, clearStart, grant, done, frameDone} === 54'h0) else begin
      errCount++;
      $error("[TB] FAIL %s: observed %h required 0", tag,
             {DrawX, DrawY, drawData, clearStart, grant, done, frameDone});
    end
  endtask

  initial begin
    Reset     = 1'b1;
    frameEdge = 1'b0;
    reqV      = '0;
    patOn     = 1'b0;
`ifdef FRAME_OVERRUN_CNT_EN
    overrunClr = 1'b0;
`endif
    for (int i = 0; i < TN; i++) begin
      rxA[i] = 0; ryA[i] = 0; rwA[i] = 0; rhA[i] = 0; baseCol[i] = 24'h0;
    end
    repeat (3) @(posedge Clk);
    #1;
    checkResetState("reset");
    Reset = 1'b0;

    curTag = "noReq";
    buildFrame(3);
    runFrame(-1, -1, -1, -1, 1'b0);

    curTag = "all1x1_a";
    for (int i = 0; i < TN; i++) begin
      rxA[i] = 116 + 3 * i; ryA[i] = 81 + i; rwA[i] = 1; rhA[i] = 1;
      baseCol[i] = 24'h100000 * (i + 1) + 24'h0000AB;
    end
    applyStimulus(4'b1111, 1'b0);
    buildFrame(2);
    runFrame(-1, -1, -1, -1, 1'b0);

    curTag = "all1x1_b";
    buildFrame(4);
    runFrame(-1, -1, -1, -1, 1'b0);

    curTag = "req0110";
    applyStimulus(4'b0110, 1'b0);
    buildFrame(1);
    runFrame(-1, -1, -1, -1, 1'b0);

    curTag = "rect3x2";
    rxA[0] = 120; ryA[0] = 82; rwA[0] = 3; rhA[0] = 2; baseCol[0] = 24'hFF0000;
    applyStimulus(4'b0001, 1'b0);
    buildFrame(2);
    runFrame(-1, -1, -1, -1, 1'b0);

    curTag = "clipEdge";
    rxA[0] = 130; ryA[0] = 87; rwA[0] = 10; rhA[0] = 4; baseCol[0] = 24'h00FF00;
    patOn = 1'b1;
    applyStimulus(4'b0001, 1'b0);
    buildFrame(3);
    runFrame(-1, 5, 17, 40, 1'b0);

    curTag = "emptyRects";
    rxA[0] = 118; ryA[0] = 83; rwA[0] = 0; rhA[0] = 3;
    rxA[1] = 121; ryA[1] = 84; rwA[1] = 4; rhA[1] = 0;
    rxA[3] = 133; ryA[3] = 88; rwA[3] = 2; rhA[3] = 2; baseCol[3] = 24'h123456;
    applyStimulus(4'b1011, 1'b0);
    buildFrame(2);
    runFrame(-1, 3, -1, 9, 1'b1);

    for (int f = 0; f < 4; f++) begin
      curTag = $sformatf("random%0d", f);
      applyStimulus(TN'($urandom), 1'b1);
      buildFrame(int'($urandom_range(1, 5)));
      if (f == 0) runFrame(-1, 2, 11, 60, 1'b0);
      else runFrame(-1, -1, -1, -1, 1'b0);
    end

    curTag = "midScan";
    rxA[0] = 118; ryA[0] = 81; rwA[0] = 8; rhA[0] = 5; baseCol[0] = 24'h0000FF;
    patOn = 1'b0;
    applyStimulus(4'b0001, 1'b0);
    buildFrame(2);
    runFrame(TW * TH + 1 + 6, -1, -1, -1, 1'b0);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    checkResetState("midScanReset");
    Reset = 1'b0;
    rrM  = 0;
    ovrM = 0;
    curTag = "afterReset";
    buildFrame(2);
    runFrame(-1, -1, -1, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

endmodule

// File: doc/frame_draw_scheduler.md
Name: frame_draw_scheduler

Overview:
- Sequences all writes into the double-buffered 410x320 frame store; the store's window spans screen X 115..524 and Y 80..399.
- Each frame: sweeps the back buffer with a clear pass, then grants up to N sprite requesters round-robin.
- For each grant, scans the requester's rectangle and emits DrawX/DrawY/draw_data; asserts frame_done until the next frame-clock edge swaps buffers.
- Sits between the game/sprite logic and the frame buffer's draw port.

Parameters:
- N, 4, number of sprite requesters (1..8)
- WIN_X0, 115, first window column
- WIN_Y0, 80, first window row
- WIN_W, 410, window width in pixels
- WIN_H, 320, window height in pixels

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- frame_clk_rising_edge  in  1  one-cycle pulse at the frame boundary
- req  in  N  per-requester draw request; level, held until its done pulse
- rect_x  in  N*10  per-requester rectangle left edge, screen coords, slice i = [10i+9:10i]
- rect_y  in  N*10  top edge
- rect_w  in  N*10  width; 0 means empty
- rect_h  in  N*10  height; 0 means empty
- pix_data  in  N*24  per-requester RGB for the current offset; combinational from off_x/off_y; 0 = transparent
- grant  out  N  one-hot; requester currently being scanned
- done  out  N  one-cycle pulse when a requester's rectangle completes
- off_x  out  10  column offset inside the granted rectangle (combinational from the counter)
- off_y  out  10  row offset inside the granted rectangle
- DrawX  out  10  registered draw column
- DrawY  out  10  registered draw row
- draw_data  out  24  registered draw colour
- clear_start  out  1  registered; forces the store to write during the clear pass
- frame_done  out  1  registered; high while in DONE

Behaviour:
- Reset values:
  - state = CLEAR, counters = 0, served mask = 0, rr pointer = 0.
  - grant = 0, done = 0, frame_done = 0, clear_start = 0.
  - DrawX = 0, DrawY = 0, draw_data = 0.
  - Reset mid-scan abandons the scan and restarts the clear; no done pulse is issued.
- Pipeline: counters and state in cycle t drive the registered DrawX/DrawY/draw_data/clear_start in cycle t+1. The pix_data slice of the granted requester is sampled in cycle t.
- CLEAR:
  - Scan cx 0..WIN_W-1 (inner loop), cy 0..WIN_H-1.
  - Emit DrawX = WIN_X0+cx, DrawY = WIN_Y0+cy, draw_data = 0, clear_start = 1.
  - 131200 cycles total. On the last pixel go to ARB; clear_start drops the cycle after.
- ARB (1 cycle):
  - Eligible = req & ~served.
  - Choose the first eligible index at or after the rr pointer, wrapping.
  - If none, go to DONE. Otherwise set grant one-hot, reset ox = oy = 0, and go to SCAN.
- SCAN:
  - ox runs 0..w-1 (inner loop), oy runs 0..h-1.
  - Emit DrawX = x+ox, DrawY = y+oy, and draw_data = pix_data slice. All arithmetic is 10-bit and wraps.
  - Any pixel outside the window emits draw_data = 0, so no write occurs. Clipping applies per pixel; the scan is not shortened.
  - On the last pixel:
    - pulse done[i] and set served[i];
    - set rr pointer = i+1 mod N;
    - clear grant, then return to ARB.
  - w = 0 or h = 0: SCAN lasts 1 cycle with no pixel written (draw_data = 0); done pulses and the requester is served.
  - req[i] dropping mid-scan does not stop the scan.
- DONE:
  - frame_done = 1, draw_data = 0, grant = 0.
  - On frame_clk_rising_edge: clear the served mask, go to CLEAR, and set frame_done = 0 the next cycle. The frame buffer swaps on that same edge.
- frame_clk_rising_edge outside DONE is ignored; the frame buffer keeps its current read buffer.
- Each requester is served at most once per frame. A requester that raises req after ARB has found no eligible requester waits for the next frame.

Optional Feature:
- Macro FRAME_OVERRUN_CNT_EN.
- When defined:
  - Extra output overrun_cnt, 16 bits, reset to 0.
  - Increments, saturating at 0xFFFF, on each frame_clk_rising_edge seen in CLEAR, ARB or SCAN (dropped frame).
  - Also adds input overrun_clr, 1 bit; when high it zeroes the counter and takes priority over an increment in the same cycle.
- When undefined: neither port exists and behaviour is otherwise identical.

Test Plan:
- Reset, no req: clear_start is high for exactly 131200 cycles; the first output is (115,80) with data 0 and the last is (524,399); then frame_done = 1 and stays high until the edge pulse.
- req = 0001, rect (200,100,3,2), pix_data = 0xFF0000: outputs are (200,100) (201,100) (202,100) (200,101) (201,101) (202,101), all 0xFF0000; done[0] pulses once, then DONE.
- req = 1111, all 1x1 rects: grant order is 0,1,2,3. Next frame with rr pointer = 0 after wrap, order is 0,1,2,3 again. With only req = 0110 the next frame, order is 1,2.
- rect (520,398,10,4): pixels with x > 524 or y > 399 emit draw_data = 0; the scan still takes 40 cycles and done pulses.
- rect_w = 0: one SCAN cycle, no nonzero draw_data, done pulses. Reset asserted mid-SCAN: grant = 0, no done, clear restarts from (115,80).
- FRAME_OVERRUN_CNT_EN: 3 edge pulses during CLEAR give overrun_cnt = 3. overrun_clr together with an edge pulse gives 0.
